// File: rtl/fifo_tx_feeder.sv
// Read-side FIFO consumer: pops one byte at a time and hands it to the UART TX
// over a valid/busy handshake, counting sent frames and flagging unaccepted bytes.
module fifo_tx_feeder #(
    parameter int WIDTH     = 8,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 err_clr,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    input  logic                 tx_busy,
    output logic                 fifo_rinc,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 tx_data_valid,
    output logic                 tx_err,
    output logic [CNT_WIDTH-1:0] tx_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 rinc_q, rinc_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rinc_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rinc_q  <= rinc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // A timeout in the same cycle as err_clr must leave the flag set, so the set is applied last.
    always_comb begin
        state_d = state_q;
        rinc_d  = 1'b0;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (enable && !fifo_empty) begin
                    data_d  = fifo_rdata;
                    rinc_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                valid_d = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    valid_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_rinc     = rinc_q;
    assign tx_data       = data_q;
    assign tx_data_valid = valid_q;
    assign tx_err        = err_q;
    assign tx_count      = cnt_q;

endmodule

// File: tb/tb_fifo_tx_feeder.sv
// Bench for fifo_tx_feeder: queue-based FIFO model, a UART TX model with programmable
// accept delay, and a transaction-level expectation of counts, flags and valid lengths.
module tb_fifo_tx_feeder;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       err_clr = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       tx_busy = 1'b0;
    logic       fifo_rinc, tx_data_valid, tx_err;
    logic [7:0] tx_data, tx_count;
    logic       fifo_rinc_w, tx_data_valid_w, tx_err_w;
    logic [7:0] tx_data_w;
    logic [1:0] tx_count_w;

    fifo_tx_feeder #(.WIDTH(8), .TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .tx_busy(tx_busy),
        .fifo_rinc(fifo_rinc), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_err(tx_err), .tx_count(tx_count)
    );

    // Narrow-counter copy sharing all stimulus, used to watch the counter wrap.
    fifo_tx_feeder #(.WIDTH(8), .TIMEOUT(TIMEOUT), .CNT_WIDTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .tx_busy(tx_busy),
        .fifo_rinc(fifo_rinc_w), .tx_data(tx_data_w), .tx_data_valid(tx_data_valid_w),
        .tx_err(tx_err_w), .tx_count(tx_count_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         delay;
        int         blen;
        int         accept;
        int         exp_valid;
        logic       exp_err;
        logic       clr_after;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] fifo_q[$];
    logic [7:0] pend_q[$];
    int tests_run = 0, tests_failed = 0;
    int rinc_count = 0, valid_rises = 0, valid_cycles = 0;
    int uart_mode = 0, wait_cnt = 0, busy_left = 0;
    int accept_delay = 0, busy_len = 1;
    int exp_count = 0;
    logic exp_err = 1'b0;
    logic prev_rinc = 1'b0, just_raised = 1'b0, saw_cancel = 1'b0;

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? 8'($urandom) : fifo_q[0];
    endtask

    task automatic push_byte(logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endtask

    // One clock: observe outputs at the falling edge, advance the FIFO and UART models, drive inputs.
    task automatic apply_stimulus();
        @(negedge clk);
        if (fifo_rinc) begin
            check_output("rinc_one_cycle", 32'(prev_rinc), 32'd0);
            rinc_count++;
            if (fifo_q.size() > 0) pend_q.push_back(fifo_q.pop_front());
        end
        prev_rinc = fifo_rinc;
        if (tx_data_valid) valid_cycles++;
        if (uart_mode == 0 && tx_data_valid) begin
            check_output("popped_byte_available", 32'(pend_q.size() > 0), 32'd1);
            if (pend_q.size() > 0) check_output("tx_data_order", 32'(tx_data), 32'(pend_q.pop_front()));
            valid_rises++;
            uart_mode = 1;
            wait_cnt = 0;
        end
        if (uart_mode == 1) begin
            if (!tx_data_valid) begin
                uart_mode = 0;
                saw_cancel = 1'b1;
            end else if (wait_cnt == accept_delay) begin
                tx_busy = 1'b1;
                busy_left = busy_len;
                uart_mode = 2;
                just_raised = 1'b1;
            end else begin
                wait_cnt++;
            end
        end else if (uart_mode == 2) begin
            if (just_raised) begin
                check_output("valid_drop_after_busy", 32'(tx_data_valid), 32'd0);
                just_raised = 1'b0;
            end
            busy_left--;
            if (busy_left == 0) begin
                tx_busy = 1'b0;
                uart_mode = 0;
            end
        end
        refresh_fifo();
    endtask

    task automatic wait_idle(bit require_empty);
        int cycles = 0;
        while (!(uart_mode == 0 && pend_q.size() == 0 && !tx_data_valid &&
                 (!require_empty || fifo_q.size() == 0)) && cycles < 500) begin
            apply_stimulus();
            cycles++;
        end
        check_output("idle_within_budget", 32'(cycles < 500), 32'd1);
        repeat (3) apply_stimulus();
    endtask

    task automatic check_totals(string tag);
        check_output({tag, "_count"}, 32'(tx_count), 32'(exp_count % 256));
        check_output({tag, "_count_wrap"}, 32'(tx_count_w), 32'(exp_count % 4));
        check_output({tag, "_err"}, 32'(tx_err), 32'(exp_err));
        check_output({tag, "_err_wrap"}, 32'(tx_err_w), 32'(exp_err));
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        apply_stimulus();
        err_clr = 1'b0;
        exp_err = 1'b0;
        check_output("err_clr_clears", 32'(tx_err), 32'd0);
    endtask

    task automatic run_frame(logic [7:0] b, int delay, int blen, int accept, int exp_valid);
        accept_delay = delay;
        busy_len = blen;
        valid_cycles = 0;
        push_byte(b);
        wait_idle(1'b1);
        exp_count += accept;
        if (accept == 0) exp_err = 1'b1;
        check_output("valid_cycles", 32'(valid_cycles), 32'(exp_valid));
    endtask

    initial begin
        int wrap_exp[5];
        int cyc;
        int rinc_before;
        vecs[0] = '{8'hA5,  2, 10, 1,  3, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 40,  1, 0, 16, 1'b1, 1'b0};
        vecs[2] = '{8'h5A,  0,  1, 1,  1, 1'b1, 1'b1};
        vecs[3] = '{8'hC3, 15,  2, 1, 16, 1'b0, 1'b0};
        vecs[4] = '{8'h7E, 16,  2, 0, 16, 1'b1, 1'b1};
        vecs[5] = '{8'hFF,  1,  5, 1,  2, 1'b0, 1'b0};
        vecs[6] = '{8'h00,  3,  1, 1,  4, 1'b0, 1'b0};
        wrap_exp = '{1, 2, 3, 0, 1};

        // Reset and idle with an empty FIFO.
        repeat (3) apply_stimulus();
        rst = 1'b1;
        repeat (20) apply_stimulus();
        check_output("idle_rinc_pulses", 32'(rinc_count), 32'd0);
        check_output("idle_rinc", 32'(fifo_rinc | fifo_rinc_w), 32'd0);
        check_output("idle_valid", 32'(tx_data_valid | tx_data_valid_w), 32'd0);
        check_output("idle_data", 32'(tx_data | tx_data_w), 32'd0);
        check_totals("reset");

        // Table of single frames: accept delays either side of the timeout.
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rinc_before = rinc_count;
            run_frame(vecs[i].data, vecs[i].delay, vecs[i].blen, vecs[i].accept, vecs[i].exp_valid);
            check_output("vec_err", 32'(tx_err), 32'(vecs[i].exp_err));
            check_output("vec_one_pop", 32'(rinc_count - rinc_before), 32'd1);
            check_totals("vec");
            if (vecs[i].clr_after) pulse_err_clr();
        end

        // Burst of eight back-to-back bytes.
        rinc_before = rinc_count;
        cyc = valid_rises;
        accept_delay = 1;
        busy_len = 3;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        wait_idle(1'b1);
        exp_count += 8;
        check_output("burst_pops", 32'(rinc_count - rinc_before), 32'd8);
        check_output("burst_frames", 32'(valid_rises - cyc), 32'd8);
        check_output("burst_fifo_empty", 32'(fifo_q.size()), 32'd0);
        check_totals("burst");

        // Timeout coinciding with err_clr: the set must win.
        err_clr = 1'b1;
        accept_delay = 40;
        saw_cancel = 1'b0;
        push_byte(8'h96);
        cyc = 0;
        while (!saw_cancel && cyc < 100) begin
            apply_stimulus();
            cyc++;
        end
        check_output("cancel_within_budget", 32'(cyc < 100), 32'd1);
        check_output("err_set_wins", 32'(tx_err), 32'd1);
        err_clr = 1'b0;
        exp_err = 1'b1;
        wait_idle(1'b1);
        check_totals("err_sticky");
        pulse_err_clr();

        // Enable gating: no pop while disabled, in-flight frame completes after disable.
        enable = 1'b0;
        rinc_before = rinc_count;
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (10) apply_stimulus();
        check_output("disabled_no_pop", 32'(rinc_count - rinc_before), 32'd0);
        enable = 1'b1;
        accept_delay = 0;
        busy_len = 8;
        cyc = 0;
        while (uart_mode != 2 && cyc < 50) begin
            apply_stimulus();
            cyc++;
        end
        enable = 1'b0;
        wait_idle(1'b0);
        repeat (5) apply_stimulus();
        exp_count += 1;
        check_output("disable_single_pop", 32'(rinc_count - rinc_before), 32'd1);
        check_output("disable_fifo_left", 32'(fifo_q.size()), 32'd1);
        check_totals("disable");
        enable = 1'b1;
        busy_len = 1;
        wait_idle(1'b1);
        exp_count += 1;
        check_totals("reenable");

        // Asynchronous reset while waiting for accept.
        accept_delay = 40;
        push_byte(8'h44);
        cyc = 0;
        while (uart_mode != 1 && cyc < 50) begin
            apply_stimulus();
            cyc++;
        end
        repeat (2) apply_stimulus();
        #2 rst = 1'b0;
        #1;
        check_output("rst_valid", 32'(tx_data_valid), 32'd0);
        check_output("rst_data", 32'(tx_data), 32'd0);
        apply_stimulus();
        rst = 1'b1;
        pend_q.delete();
        exp_count = 0;
        exp_err = 1'b0;
        check_totals("rst_mid");
        run_frame(8'h45, 0, 2, 1, 1);
        check_totals("after_rst");

        // Randomized frames: enough accepted ones to wrap the 8-bit counter.
        for (int i = 0; i < 360; i++) begin
            int d, r;
            r = $urandom_range(0, 9);
            d = (r < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(12, 19));
            run_frame(8'($urandom), d, int'($urandom_range(1, 4)),
                      (d < TIMEOUT) ? 1 : 0, (d < TIMEOUT) ? d + 1 : TIMEOUT);
            check_totals("rand");
            if (exp_err) pulse_err_clr();
        end

        // Counter wrap on the 2-bit instance.
        rst = 1'b0;
        apply_stimulus();
        rst = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 5; i++) begin
            run_frame(8'(8'h50 + i), 0, 1, 1, 1);
            check_output("wrap_seq", 32'(tx_count_w), 32'(wrap_exp[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_tx_feeder.md
Name: fifo_tx_feeder

Overview:
Read-side consumer of the async FIFO. It runs in the FIFO read clock domain and pops one byte at a time when the FIFO is not empty. Each popped byte is handed to the UART transmitter with a valid/busy handshake. The block also counts completed frames and flags a sticky error if the transmitter never accepts a byte.

Parameters:
WIDTH, 8, data width; must match the FIFO WIDTH.
TIMEOUT, 16, number of WAIT_ACK cycles without tx_busy rising before the byte is abandoned; minimum 2.
CNT_WIDTH, 8, width of the sent-frame counter.

Ports:
clk  input  1  read-domain clock (same as the FIFO rclk).
rst  input  1  asynchronous active-low reset.
enable  input  1  allows new pops when high; an in-flight byte always completes.
err_clr  input  1  synchronous clear of tx_err.
fifo_empty  input  1  FIFO empty flag.
fifo_rdata  input  WIDTH  FIFO read data; valid whenever fifo_empty=0.
tx_busy  input  1  UART TX busy; high for the whole frame.
fifo_rinc  output  1  one-cycle pop strobe to the FIFO rinc.
tx_data  output  WIDTH  byte presented to the UART TX.
tx_data_valid  output  1  byte-valid to the UART TX.
tx_err  output  1  sticky timeout flag.
tx_count  output  CNT_WIDTH  completed-frame counter; wraps at 2^CNT_WIDTH.

Behaviour:
- Reset (rst=0, async):
  - state goes to IDLE.
  - fifo_rinc=0, tx_data=0, tx_data_valid=0, tx_err=0, tx_count=0; timeout counter cleared.
  - Reset mid-frame abandons the byte. Any pop already issued is not undone.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States and transitions:
  - IDLE: when enable=1 and fifo_empty=0, on the clock edge: tx_data<=fifo_rdata, fifo_rinc<=1, go to LOAD. Otherwise stay in IDLE with all strobes at 0.
  - LOAD (one cycle): fifo_rinc=1 for this cycle only. tx_data_valid<=1 and the timeout counter is cleared. Go to WAIT_ACK unconditionally.
  - WAIT_ACK: tx_data_valid and tx_data are held stable.
    - If tx_busy=1: tx_data_valid<=0, go to WAIT_DONE.
    - Else, if the timeout counter equals TIMEOUT-1: tx_data_valid<=0, tx_err<=1, go to IDLE (byte dropped, tx_count unchanged).
    - Else: increment the timeout counter.
  - WAIT_DONE: wait for tx_busy=0. On that cycle, tx_count<=tx_count+1 and go to IDLE.
- Latency and throughput:
  - First byte: fifo_empty falling to tx_data_valid rising is 2 clk edges.
  - The minimum IDLE-to-IDLE loop is 4 cycles. This guarantees the FIFO empty/pointer update after a pop is visible before the next IDLE decision, so a pop is never issued twice for one entry.
  - Exactly one fifo_rinc pulse is issued per byte captured.
- Boundary conditions:
  - fifo_empty asserted while in LOAD/WAIT_*: no effect; the byte is already captured.
  - enable deasserted mid-frame: the current byte completes normally, and no new pop occurs afterwards.
  - tx_busy already high when entering WAIT_ACK: this is treated as accept on the first WAIT_ACK cycle.
  - err_clr and a timeout in the same cycle: the set wins (tx_err=1).
  - err_clr alone clears tx_err on the next edge.
  - tx_count=2^CNT_WIDTH-1 plus one frame wraps to 0.
  - tx_busy glitching low for 1 cycle during a frame is treated as frame end. The UART TX must hold busy solid.

Test Plan:
- Reset and idle: rst=0 for 3 cycles, then 1 with fifo_empty=1 for 20 cycles -> all outputs stay 0 and fifo_rinc never pulses.
- Single byte: fifo_rdata=8'hA5, fifo_empty falls; tx_busy modelled to rise 2 cycles after valid and stay high 10 cycles -> exactly one fifo_rinc pulse, tx_data=8'hA5, valid drops the cycle after busy rises, tx_count=1.
- Burst of 8: FIFO model preloaded with 8'h01..8'h08 -> 8 rinc pulses, tx_data sequence 01..08 in order with no duplicates or skips, tx_count=8, FIFO ends empty.
- Timeout: tx_busy tied 0, one byte 8'h3C -> valid high for exactly 16 cycles then low, tx_err=1, tx_count=0. Then err_clr pulse -> tx_err=0.
- Enable gating and reset mid-frame:
  - enable=0 with FIFO non-empty -> no pop.
  - enable=1 -> pop. Drop enable during WAIT_DONE -> frame completes, tx_count+1, no further pop.
  - Assert rst during WAIT_ACK -> valid=0 immediately, state IDLE.
- Counter wrap: CNT_WIDTH=2, send 5 frames -> tx_count sequence 1,2,3,0,1.
